uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_bit_sync.sv | 23 ++
 rtl/uart_rx.sv | 170 +++++++++++++++++
 tb/tb_uart_rx.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receive-state encoding and baud divider helper.
package uart_pkg;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP,
        RX_BREAK
    } rx_state_t;

    // Clocks per serial bit, integer truncation.
    function automatic int unsigned baud_div(input int unsigned clk_freq,
                                             input int unsigned baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_bit_sync.sv
// Two-flop synchronizer for a single asynchronous bit with a configurable reset value.
module uart_bit_sync #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 1 start, DATA_BITS LSB-first, optional even parity, 1 stop bit.
// Define UART_RX_PARITY_EN to include the parity bit in the frame.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQUENCY = 50_000_000,
    parameter int unsigned BAUD_RATE     = 115_200,
    parameter int unsigned DATA_BITS     = 7
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx_serial,
    output logic [DATA_BITS-1:0] output_data,
    output logic                 rx_valid,
    output logic                 rx_busy,
    output logic                 frame_error,
    output logic                 parity_error
);

    localparam int unsigned BAUD_DIV = baud_div(CLK_FREQUENCY, BAUD_RATE);
    localparam int unsigned HALF_DIV = BAUD_DIV / 2;
    localparam int unsigned CNT_W    = $clog2(BAUD_DIV + 1);
    localparam int unsigned IDX_W    = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_DIV - 1);
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

`ifdef UART_RX_PARITY_EN
    localparam rx_state_t AFTER_DATA = RX_PARITY;
`else
    localparam rx_state_t AFTER_DATA = RX_STOP;
`endif

    rx_state_t             state;
    logic [CNT_W-1:0]      cnt;
    logic [IDX_W-1:0]      bit_idx;
    logic [DATA_BITS-1:0]  shift_reg;
    logic                  line;

`ifdef UART_RX_PARITY_EN
    logic                  parity_bad;
`else
    assign parity_error = 1'b0;
`endif

    uart_bit_sync #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rx_serial),
        .q     (line)
    );

    // Frame FSM; status pulses default low and are raised for exactly one clk.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= RX_IDLE;
            cnt          <= '0;
            bit_idx      <= '0;
            shift_reg    <= '0;
            output_data  <= '0;
            rx_valid     <= 1'b0;
            rx_busy      <= 1'b0;
            frame_error  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_error <= 1'b0;
            parity_bad   <= 1'b0;
`endif
        end else begin
            rx_valid     <= 1'b0;
            frame_error  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_error <= 1'b0;
`endif
            case (state)
                RX_IDLE: begin
                    if (!line) begin
                        state   <= RX_START;
                        cnt     <= '0;
                        rx_busy <= 1'b1;
                    end
                end

                // Mid-start-bit check rejects glitches shorter than half a bit.
                RX_START: begin
                    if (cnt == HALF_LAST) begin
                        cnt <= '0;
                        if (!line) begin
                            state   <= RX_DATA;
                            bit_idx <= '0;
                        end else begin
                            state   <= RX_IDLE;
                            rx_busy <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                RX_DATA: begin
                    if (cnt == BAUD_LAST) begin
                        cnt       <= '0;
                        shift_reg <= {line, shift_reg[DATA_BITS-1:1]};
                        if (bit_idx == IDX_LAST) begin
                            state <= AFTER_DATA;
                        end else begin
                            bit_idx <= bit_idx + IDX_W'(1);
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

`ifdef UART_RX_PARITY_EN
                RX_PARITY: begin
                    if (cnt == BAUD_LAST) begin
                        cnt        <= '0;
                        parity_bad <= line ^ (^shift_reg);
                        state      <= RX_STOP;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
`endif

                RX_STOP: begin
                    if (cnt == BAUD_LAST) begin
                        cnt <= '0;
                        if (!line) begin
                            frame_error <= 1'b1;
                            state       <= RX_BREAK;
                        end else begin
                            state   <= RX_IDLE;
                            rx_busy <= 1'b0;
`ifdef UART_RX_PARITY_EN
                            if (parity_bad) begin
                                parity_error <= 1'b1;
                            end else begin
                                output_data <= shift_reg;
                                rx_valid    <= 1'b1;
                            end
`else
                            output_data <= shift_reg;
                            rx_valid    <= 1'b1;
`endif
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                // Held-low line: wait for idle before hunting for a new start bit.
                RX_BREAK: begin
                    if (line) begin
                        state   <= RX_IDLE;
                        rx_busy <= 1'b0;
                    end
                end

                default: begin
                    state   <= RX_IDLE;
                    rx_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Randomized bench for uart_rx: a frame-level scoreboard predicts each status pulse.
// Build with UART_RX_PARITY_EN defined to exercise the parity frame format.
module tb_uart_rx;

    localparam int CLK_FREQ = 50_000_000;
    localparam int BAUD     = 115_200;
    localparam int DB       = 7;
    localparam int BD       = CLK_FREQ / BAUD;
    localparam int HALF     = BD / 2;
`ifdef UART_RX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    // rx_valid/error pulse: 1.5 bits + data [+ parity] bits, 2 sync clks, 1 register clk.
    localparam int LAT = (3 * BD) / 2 + (DB + PAR) * BD + 3;

    localparam int K_NONE  = 0;
    localparam int K_VALID = 1;
    localparam int K_FERR  = 2;
    localparam int K_PERR  = 3;

    typedef struct {
        int          kind;
        logic [DB-1:0] data;
        int          fall_cyc;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          rx_serial;
    logic [DB-1:0] output_data;
    logic          rx_valid;
    logic          rx_busy;
    logic          frame_error;
    logic          parity_error;

    int            checks   = 0;
    int            failures = 0;
    int            cyc      = 0;
    exp_t          expq[$];
    logic [DB-1:0] last_good = '0;
    logic          prev_pulse = 1'b0;
    int            mon_kind;
    exp_t          mon_e;

    uart_rx #(
        .CLK_FREQUENCY (CLK_FREQ),
        .BAUD_RATE     (BAUD),
        .DATA_BITS     (DB)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_serial    (rx_serial),
        .output_data  (output_data),
        .rx_valid     (rx_valid),
        .rx_busy      (rx_busy),
        .frame_error  (frame_error),
        .parity_error (parity_error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic drive(input logic v, input int n);
        rx_serial = v;
        repeat (n) @(negedge clk);
    endtask

    // Transmits one frame at bit_clks clocks per bit and queues its predicted outcome.
    task automatic send_frame(input logic [DB-1:0] data, input int bit_clks,
                              input logic par_bit, input logic stop_bit);
        exp_t e;
        e.data     = data;
        e.fall_cyc = cyc;
        if (!stop_bit)
            e.kind = K_FERR;
        else if (PAR != 0 && par_bit != ^data)
            e.kind = K_PERR;
        else
            e.kind = K_VALID;
        expq.push_back(e);
        drive(1'b0, bit_clks);
        for (int i = 0; i < DB; i++) drive(data[i], bit_clks);
        if (PAR != 0) drive(par_bit, bit_clks);
        drive(stop_bit, bit_clks);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_data"},  32'(output_data),  32'd0);
        check({tag, "_valid"}, 32'(rx_valid),     32'd0);
        check({tag, "_busy"},  32'(rx_busy),      32'd0);
        check({tag, "_ferr"},  32'(frame_error),  32'd0);
        check({tag, "_perr"},  32'(parity_error), 32'd0);
    endtask

    // Scoreboard: every status pulse must match the oldest predicted frame outcome.
    always @(negedge clk) begin
        mon_kind = rx_valid ? K_VALID : frame_error ? K_FERR : parity_error ? K_PERR : K_NONE;
        if (mon_kind != K_NONE) begin
            check("pulse_exclusive", 32'(int'(rx_valid) + int'(frame_error) + int'(parity_error)), 32'd1);
            check("pulse_width", 32'(prev_pulse), 32'd0);
            if (expq.size() == 0) begin
                check("pulse_kind_unexpected", 32'(mon_kind), 32'(K_NONE));
            end else begin
                mon_e = expq.pop_front();
                check("pulse_kind", 32'(mon_kind), 32'(mon_e.kind));
                check("latency",
                      ((cyc - mon_e.fall_cyc) >= LAT - 2 && (cyc - mon_e.fall_cyc) <= LAT + 2)
                          ? 32'(LAT) : 32'(cyc - mon_e.fall_cyc),
                      32'(LAT));
                if (mon_e.kind == K_VALID) last_good = mon_e.data;
                check("output_data", 32'(output_data), 32'(last_good));
            end
        end
        prev_pulse = (mon_kind != K_NONE);
    end

    initial begin
        int t;
        logic [DB-1:0] d;
        int rate;
        logic stop;
        logic par;

        reset     = 1'b1;
        rx_serial = 1'b1;
        repeat (5) @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b0;
        drive(1'b1, 20);

        // Nominal-rate frame.
        send_frame(7'h55, BD, ^7'h55, 1'b1);
        drive(1'b1, BD);

        // Short low glitch on an idle line.
        t = 0;
        rx_serial = 1'b0;
        repeat (100) @(negedge clk);
        t = 100;
        check("glitch_busy_high", 32'(rx_busy), 32'd1);
        rx_serial = 1'b1;
        while (rx_busy && t < 1000) begin
            @(negedge clk);
            t++;
        end
        check("glitch_busy_fall", (t <= HALF + 3) ? 32'(HALF + 3) : 32'(t), 32'(HALF + 3));
        drive(1'b1, BD);

        // Frame error, long break, then recovery.
        send_frame(7'h2A, BD, ^7'h2A, 1'b0);
        drive(1'b0, 5000);
        check("break_busy", 32'(rx_busy), 32'd1);
        drive(1'b1, 2 * BD);
        send_frame(7'h11, BD, ^7'h11, 1'b1);
        drive(1'b1, BD);

        // Fast transmitter, back-to-back frames.
        send_frame(7'h3C, 429, ^7'h3C, 1'b1);
        send_frame(7'h7F, 429, ^7'h7F, 1'b1);
        send_frame(7'h00, 429, ^7'h00, 1'b1);
        drive(1'b1, 2 * BD);

`ifdef UART_RX_PARITY_EN
        send_frame(7'h03, BD, 1'b1, 1'b1);
        drive(1'b1, BD);
        send_frame(7'h03, BD, 1'b0, 1'b1);
        drive(1'b1, BD);
`endif

        // Reset after the third data bit aborts the frame silently.
        d = DB'($urandom);
        drive(1'b0, BD);
        for (int i = 0; i < 3; i++) drive(d[i], BD);
        reset     = 1'b1;
        rx_serial = 1'b1;
        last_good = '0;
        repeat (10) @(negedge clk);
        check_reset_outputs("midframe_reset");
        reset = 1'b0;
        drive(1'b1, 50);
        send_frame(7'h0F, BD, ^7'h0F, 1'b1);
        drive(1'b1, BD);

        // Random frames: data, +/-2% rate, occasional bad stop or parity, random gaps.
        for (int n = 0; n < 8; n++) begin
            d    = DB'($urandom);
            rate = $urandom_range(426, 442);
            stop = ($urandom_range(0, 4) != 0);
            par  = (^d) ^ ($urandom_range(0, 3) == 0);
            send_frame(d, rate, par, stop);
            if (!stop) begin
                drive(1'b0, $urandom_range(0, 2000));
                drive(1'b1, BD);
            end else if ($urandom_range(0, 1) == 1) begin
                drive(1'b1, $urandom_range(1, 300));
            end
        end
        drive(1'b1, 2 * BD);

        check("pending_frames", 32'(expq.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
